// File: rtl/vga_sync_monitor.sv
// Receive-side timing checker for the solo_squash VGA stream: measures line and
// frame timing, counts lit pixels per frame and tracks lock against nominal timing.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_ACTIVE = 0,
  parameter int LOCK_FRAMES = 2,
  parameter int HW          = 11,
  parameter int VW          = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          red,
  input  logic          green,
  input  logic          blue,
  output logic          locked,
  output logic [HW-1:0] line_period,
  output logic [HW-1:0] hsync_width,
  output logic [VW-1:0] frame_lines,
  output logic [19:0]   lit_pixels,
  output logic [7:0]    err_count,
  output logic          frame_strobe
);

  localparam logic ACT = (SYNC_ACTIVE != 0);
  localparam int   GW  = $clog2(LOCK_FRAMES + 1);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic          hs_r, vs_r, hs_p, vs_p, rgb_r;
  logic          hs_on, hs_lead, hs_trail, vs_lead;
  logic [HW-1:0] h_cnt, w_cnt, period_now;
  logic          h_max, timeout, line_armed, line_bad;
  logic [VW-1:0] v_cnt, v_next;
  logic [19:0]   lit_cnt;
  logic          frame_bad, frame_bad_now, frame_good;
  logic [1:0]    state;
  logic [GW-1:0] good_cnt, good_inc;

  // Sync copies reset to the inactive level so reset itself never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_r  <= ~ACT;
      vs_r  <= ~ACT;
      hs_p  <= ~ACT;
      vs_p  <= ~ACT;
      rgb_r <= 1'b0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      hs_p  <= hs_r;
      vs_p  <= vs_r;
      rgb_r <= red | green | blue;
    end
  end

  always_comb begin
    hs_on      = (hs_r == ACT);
    hs_lead    = hs_on && (hs_p != ACT);
    hs_trail   = !hs_on && (hs_p == ACT);
    vs_lead    = (vs_r == ACT) && (vs_p != ACT);
    h_max      = &h_cnt;
    timeout    = h_max && !hs_lead;
    period_now = h_max ? h_cnt : h_cnt + 1'b1;
    line_bad   = hs_lead && line_armed &&
                 ((period_now != HW'(H_TOTAL)) || (hsync_width != HW'(H_SYNC)));
    // A line whose leading edge coincides with vsync still belongs to the ending frame.
    v_next        = (hs_lead && !(&v_cnt)) ? v_cnt + 1'b1 : v_cnt;
    frame_bad_now = frame_bad || line_bad;
    frame_good    = (v_next == VW'(V_TOTAL)) && !frame_bad_now;
    good_inc      = good_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      w_cnt       <= '0;
      line_period <= '0;
      hsync_width <= '0;
      line_armed  <= 1'b0;
    end else begin
      if (hs_lead) begin
        line_period <= period_now;
        h_cnt       <= '0;
        line_armed  <= 1'b1;
      end else if (!h_max) begin
        h_cnt <= h_cnt + 1'b1;
      end
      if (hs_trail) begin
        hsync_width <= w_cnt;
        w_cnt       <= '0;
      end else if (hs_on && !(&w_cnt)) begin
        w_cnt <= w_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_cnt        <= '0;
      lit_cnt      <= '0;
      frame_bad    <= 1'b0;
      frame_lines  <= '0;
      lit_pixels   <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= vs_lead;
      if (vs_lead) begin
        frame_lines <= v_next;
        lit_pixels  <= lit_cnt;
        v_cnt       <= '0;
        lit_cnt     <= '0;
        frame_bad   <= 1'b0;
      end else begin
        v_cnt     <= v_next;
        frame_bad <= frame_bad_now;
        if (rgb_r && !(&lit_cnt)) begin
          lit_cnt <= lit_cnt + 1'b1;
        end
      end
    end
  end

  // Loss of hsync drops lock without counting an error; measured results are kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_SEARCH;
      good_cnt  <= '0;
      locked    <= 1'b0;
      err_count <= '0;
    end else if (timeout) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else if (vs_lead) begin
      case (state)
        ST_SEARCH: begin
          state    <= ST_CHECK;
          good_cnt <= '0;
        end
        ST_CHECK: begin
          if (!frame_good) begin
            good_cnt <= '0;
          end else if (good_inc >= GW'(LOCK_FRAMES)) begin
            good_cnt <= good_inc;
            state    <= ST_LOCKED;
            locked   <= 1'b1;
          end else begin
            good_cnt <= good_inc;
          end
        end
        ST_LOCKED: begin
          if (!frame_good) begin
            if (!(&err_count)) begin
              err_count <= err_count + 1'b1;
            end
            state    <= ST_CHECK;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        end
        default: begin
          state    <= ST_SEARCH;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a shrunken 40x12 raster (sync 6 clocks, vsync 2 lines)
// so every scenario fits a short run; frame results are scoreboarded per vsync edge.
module tb_vga_sync_monitor;

  localparam int HT  = 40;
  localparam int HS  = 6;
  localparam int VT  = 12;
  localparam int HWB = 6;
  localparam int VWB = 5;

  typedef struct packed {
    logic [VWB-1:0] lines;
    logic [19:0]    lit;
    logic [HWB-1:0] period;
    logic [HWB-1:0] width;
    logic           lck;
    logic [7:0]     err;
  } frame_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           hsync = 1'b1;
  logic           vsync = 1'b1;
  logic           red = 1'b0;
  logic           green = 1'b0;
  logic           blue = 1'b0;
  logic           locked;
  logic [HWB-1:0] line_period;
  logic [HWB-1:0] hsync_width;
  logic [VWB-1:0] frame_lines;
  logic [19:0]    lit_pixels;
  logic [7:0]     err_count;
  logic           frame_strobe;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .SYNC_ACTIVE(0),
    .LOCK_FRAMES(2), .HW(HWB), .VW(VWB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .locked(locked), .line_period(line_period), .hsync_width(hsync_width),
    .frame_lines(frame_lines), .lit_pixels(lit_pixels), .err_count(err_count),
    .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  frame_t exp_q[$];
  frame_t obs_q[$];
  bit     care_q[$];
  frame_t e, o, tmp;
  bit     cr;
  int     waited;

  // Reference model of the lock FSM and the frame currently being driven.
  int m_state = 0;
  int m_good = 0;
  int m_err = 0;
  int cur_lines = 0;
  int cur_lit = 0;
  bit cur_bad = 1'b0;
  bit cur_valid = 1'b0;
  int last_period = HT;

  always @(negedge clk) begin
    if (reset_n && frame_strobe) begin
      tmp.lines  = frame_lines;
      tmp.lit    = lit_pixels;
      tmp.period = line_period;
      tmp.width  = hsync_width;
      tmp.lck    = locked;
      tmp.err    = err_count;
      obs_q.push_back(tmp);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Line 0 of every frame closes the previous one, so its expectation is queued first.
  task automatic drive_frame(input int n_lines, input int last_len, input bit with_red,
                             input int voff);
    frame_t ef;
    bit good;
    int per;
    for (int l = 0; l < n_lines; l++) begin
      cur_lines++;
      if (last_period != HT) cur_bad = 1'b1;
      if (l == 0) begin
        good = cur_valid && (cur_lines == VT) && !cur_bad;
        case (m_state)
          0: begin m_state = 1; m_good = 0; end
          1: begin
            if (good) begin
              m_good++;
              if (m_good >= 2) m_state = 2;
            end else begin
              m_good = 0;
            end
          end
          default: begin
            if (!good) begin
              m_err   = (m_err < 255) ? m_err + 1 : 255;
              m_state = 1;
              m_good  = 0;
            end
          end
        endcase
        ef.lines  = VWB'(cur_lines);
        ef.lit    = 20'(cur_lit);
        ef.period = HWB'(last_period);
        ef.width  = HWB'(HS);
        ef.lck    = (m_state == 2);
        ef.err    = 8'(m_err);
        exp_q.push_back(ef);
        care_q.push_back(cur_valid);
        cur_lines = 0;
        cur_lit   = 0;
        cur_bad   = 1'b0;
        cur_valid = 1'b1;
      end
      per = (l == n_lines - 1) ? last_len : HT;
      for (int i = 0; i < per; i++) begin
        @(negedge clk);
        hsync = (i < HS) ? 1'b0 : 1'b1;
        vsync = ((l * HT + i) >= voff && (l * HT + i) < voff + 2 * HT) ? 1'b0 : 1'b1;
        red   = with_red && l >= 2 && l < 10 && i >= 12 && i < 32;
      end
      last_period = per;
      if (with_red && l >= 2 && l < 10) cur_lit += 20;
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({locked, line_period, hsync_width, frame_lines, lit_pixels, err_count, frame_strobe} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got locked=%0d period=%0d width=%0d lines=%0d lit=%0d err=%0d strobe=%0d want all 0",
               locked, line_period, hsync_width, frame_lines, lit_pixels, err_count, frame_strobe);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_ideal_lock();
    repeat (4) drive_frame(VT, HT, 1'b0, 0);
    while (exp_q.size() > 0) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < 100) begin @(negedge clk); waited++; end
      e = exp_q.pop_front(); cr = care_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL ideal_strobe: no frame_strobe within 100 clocks, want one");
      end else begin
        o = obs_q.pop_front();
        if ({o.lck, o.err} !== {e.lck, e.err}) begin
          bad++; $display("[TB] FAIL ideal_lock: got locked=%0d err=%0d want locked=%0d err=%0d", o.lck, o.err, e.lck, e.err);
        end
        if (cr) begin
          total++;
          if ({o.lines, o.lit, o.period, o.width} !== {e.lines, e.lit, e.period, e.width}) begin
            bad++; $display("[TB] FAIL ideal_results: got lines=%0d lit=%0d period=%0d width=%0d want lines=%0d lit=%0d period=%0d width=%0d",
                            o.lines, o.lit, o.period, o.width, e.lines, e.lit, e.period, e.width);
          end
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("[TB] FAIL ideal_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_bad_line();
    drive_frame(VT, HT + 1, 1'b0, 0);
    repeat (3) drive_frame(VT, HT, 1'b0, 0);
    while (exp_q.size() > 0) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < 100) begin @(negedge clk); waited++; end
      e = exp_q.pop_front(); cr = care_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL badline_strobe: no frame_strobe within 100 clocks, want one");
      end else begin
        o = obs_q.pop_front();
        if ({o.lck, o.err} !== {e.lck, e.err}) begin
          bad++; $display("[TB] FAIL badline_lock: got locked=%0d err=%0d want locked=%0d err=%0d", o.lck, o.err, e.lck, e.err);
        end
        if (cr) begin
          total++;
          if ({o.lines, o.lit, o.period, o.width} !== {e.lines, e.lit, e.period, e.width}) begin
            bad++; $display("[TB] FAIL badline_results: got lines=%0d lit=%0d period=%0d width=%0d want lines=%0d lit=%0d period=%0d width=%0d",
                            o.lines, o.lit, o.period, o.width, e.lines, e.lit, e.period, e.width);
          end
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("[TB] FAIL badline_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_lit_pixels();
    drive_frame(VT, HT, 1'b1, 0);
    drive_frame(VT, HT, 1'b0, 0);
    while (exp_q.size() > 0) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < 100) begin @(negedge clk); waited++; end
      e = exp_q.pop_front(); cr = care_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL lit_strobe: no frame_strobe within 100 clocks, want one");
      end else begin
        o = obs_q.pop_front();
        if ({o.lck, o.err} !== {e.lck, e.err}) begin
          bad++; $display("[TB] FAIL lit_lock: got locked=%0d err=%0d want locked=%0d err=%0d", o.lck, o.err, e.lck, e.err);
        end
        if (cr) begin
          total++;
          if ({o.lines, o.lit, o.period, o.width} !== {e.lines, e.lit, e.period, e.width}) begin
            bad++; $display("[TB] FAIL lit_results: got lines=%0d lit=%0d period=%0d width=%0d want lines=%0d lit=%0d period=%0d width=%0d",
                            o.lines, o.lit, o.period, o.width, e.lines, e.lit, e.period, e.width);
          end
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("[TB] FAIL lit_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  // vsync falling mid-line instead of on an hsync edge must give the same line count.
  task automatic test_offset_vsync();
    drive_frame(VT, HT, 1'b1, 20);
    drive_frame(VT, HT, 1'b0, 20);
    drive_frame(VT, HT, 1'b0, 0);
    while (exp_q.size() > 0) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < 100) begin @(negedge clk); waited++; end
      e = exp_q.pop_front(); cr = care_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL offset_strobe: no frame_strobe within 100 clocks, want one");
      end else begin
        o = obs_q.pop_front();
        if ({o.lck, o.err} !== {e.lck, e.err}) begin
          bad++; $display("[TB] FAIL offset_lock: got locked=%0d err=%0d want locked=%0d err=%0d", o.lck, o.err, e.lck, e.err);
        end
        if (cr) begin
          total++;
          if ({o.lines, o.lit, o.period, o.width} !== {e.lines, e.lit, e.period, e.width}) begin
            bad++; $display("[TB] FAIL offset_results: got lines=%0d lit=%0d period=%0d width=%0d want lines=%0d lit=%0d period=%0d width=%0d",
                            o.lines, o.lit, o.period, o.width, e.lines, e.lit, e.period, e.width);
          end
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("[TB] FAIL offset_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_timeout();
    drive_frame(3, HT, 1'b0, 0);
    repeat (100) begin
      @(negedge clk);
      hsync = 1'b1; vsync = 1'b1; red = 1'b0;
    end
    m_state = 0; m_good = 0; cur_valid = 1'b0; last_period = (1 << HWB) - 1;
    total++;
    if (locked !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_unlock: got locked=%0d want 0", locked);
    end
    repeat (3) drive_frame(VT, HT, 1'b0, 0);
    while (exp_q.size() > 0) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < 100) begin @(negedge clk); waited++; end
      e = exp_q.pop_front(); cr = care_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL timeout_strobe: no frame_strobe within 100 clocks, want one");
      end else begin
        o = obs_q.pop_front();
        if ({o.lck, o.err} !== {e.lck, e.err}) begin
          bad++; $display("[TB] FAIL timeout_lock: got locked=%0d err=%0d want locked=%0d err=%0d", o.lck, o.err, e.lck, e.err);
        end
        if (cr) begin
          total++;
          if ({o.lines, o.lit, o.period, o.width} !== {e.lines, e.lit, e.period, e.width}) begin
            bad++; $display("[TB] FAIL timeout_results: got lines=%0d lit=%0d period=%0d width=%0d want lines=%0d lit=%0d period=%0d width=%0d",
                            o.lines, o.lit, o.period, o.width, e.lines, e.lit, e.period, e.width);
          end
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("[TB] FAIL timeout_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_reset_midframe();
    drive_frame(5, HT, 1'b0, 0);
    repeat (3) @(negedge clk);
    exp_q.pop_front(); care_q.pop_front();
    total++;
    if (obs_q.size() != 1 || obs_q[0].lck !== 1'b1) begin
      bad++; $display("[TB] FAIL midreset_prelock: got %0d strobes want 1 with locked=1", obs_q.size());
    end
    obs_q.delete();
    reset_n = 1'b0;
    #1;
    total++;
    if ({locked, line_period, hsync_width, frame_lines, lit_pixels, err_count, frame_strobe} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got locked=%0d period=%0d width=%0d lines=%0d lit=%0d err=%0d strobe=%0d want all 0",
               locked, line_period, hsync_width, frame_lines, lit_pixels, err_count, frame_strobe);
    end
    m_state = 0; m_good = 0; m_err = 0; cur_valid = 1'b0; cur_lines = 0; cur_lit = 0; cur_bad = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) drive_frame(VT, HT, 1'b0, 0);
    while (exp_q.size() > 0) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < 100) begin @(negedge clk); waited++; end
      e = exp_q.pop_front(); cr = care_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL midreset_strobe: no frame_strobe within 100 clocks, want one");
      end else begin
        o = obs_q.pop_front();
        if ({o.lck, o.err} !== {e.lck, e.err}) begin
          bad++; $display("[TB] FAIL midreset_lock: got locked=%0d err=%0d want locked=%0d err=%0d", o.lck, o.err, e.lck, e.err);
        end
        if (cr) begin
          total++;
          if ({o.lines, o.lit, o.period, o.width} !== {e.lines, e.lit, e.period, e.width}) begin
            bad++; $display("[TB] FAIL midreset_results: got lines=%0d lit=%0d period=%0d width=%0d want lines=%0d lit=%0d period=%0d width=%0d",
                            o.lines, o.lit, o.period, o.width, e.lines, e.lit, e.period, e.width);
          end
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("[TB] FAIL midreset_extra: got %0d extra strobes want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_ideal_lock();
    test_bad_line();
    test_lit_pixels();
    test_offset_vsync();
    test_timeout();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
